// File: rtl/serial_add.sv
// serial_add: multi-cycle adder that adds chunk_p bits per clock through one narrow
// adder slice, carrying between chunks in a register, with valid/ready on both sides.
module serial_add #(
    parameter int width_p = 8,
    parameter int chunk_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [width_p-1:0] a_i,
    input  logic [width_p-1:0] b_i,
    input  logic               carry_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [width_p-1:0] sum_o,
    output logic               carry_o,
    output logic               overflow_o
);
    // state | meaning
    // IDLE  | waiting for operands, ready_o high
    // BUSY  | adding one chunk per edge
    // DONE  | result presented until the consumer takes it

    if (width_p < 1 || chunk_p < 1 || chunk_p > width_p || (width_p % chunk_p) != 0) begin : g_param_check
        $error("serial_add: width_p must be >= 1 and chunk_p must be >= 1, <= width_p and divide width_p");
    end

    localparam int n_lp     = width_p / chunk_p;
    localparam int cnt_w_lp = (n_lp > 1) ? $clog2(n_lp) : 1;
    localparam logic [width_p-1:0] mask_lp = {width_p{1'b1}} >> (width_p - chunk_p);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [width_p-1:0]    a_q, a_d;
    logic [width_p-1:0]    b_q, b_d;
    logic                  cy_q, cy_d;
    logic [width_p-1:0]    work_q, work_d;
    logic [cnt_w_lp-1:0]   cnt_q, cnt_d;
    logic [width_p-1:0]    sum_q, sum_d;
    logic                  carry_q, carry_d;
    logic                  ovf_q, ovf_d;

    logic [31:0]           base;
    logic [chunk_p-1:0]    a_ch;
    logic [chunk_p-1:0]    b_ch;
    logic [chunk_p:0]      chunk_res;
    logic                  msb_cin;

    always_comb begin
        base      = 32'(cnt_q) * 32'(chunk_p);
        a_ch      = chunk_p'(a_q >> base);
        b_ch      = chunk_p'(b_q >> base);
        chunk_res = {1'b0, a_ch} + {1'b0, b_ch} + {{chunk_p{1'b0}}, cy_q};
        // Carry into the top bit of the slice, recovered from that bit's sum.
        msb_cin   = chunk_res[chunk_p-1] ^ a_ch[chunk_p-1] ^ b_ch[chunk_p-1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cy_d    = cy_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    cy_d    = carry_i;
                    cnt_d   = '0;
                    work_d  = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d = (work_q & ~(mask_lp << base)) | (width_p'(chunk_res[chunk_p-1:0]) << base);
                cy_d   = chunk_res[chunk_p];
                cnt_d  = cnt_q + 1'b1;
                // Published outputs only change here, so they hold the last result elsewhere.
                if (cnt_q == cnt_w_lp'(n_lp - 1)) begin
                    sum_d   = work_d;
                    carry_d = chunk_res[chunk_p];
                    ovf_d   = msb_cin ^ chunk_res[chunk_p];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cy_q    <= 1'b0;
            work_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cy_q    <= cy_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ready_o    = (state_q == IDLE);
    assign valid_o    = (state_q == DONE);
    assign sum_o      = sum_q;
    assign carry_o    = carry_q;
    assign overflow_o = ovf_q;

endmodule

// File: doc/serial_add.md
Name: serial_add

Overview:
- Parametrised multi-cycle adder that computes a_i + b_i + carry_i for width_p-bit operands.
- Processes chunk_p bits per clock, with a registered carry between chunks, so wide adds reuse one narrow adder slice.
- Valid/ready handshake on both the input and output sides.
- Sits in the arithmetic datapath as the sequential successor to the single-bit combinational full adder.

Parameters:
- width_p, 8: operand and sum width in bits; must be ≥1.
- chunk_p, 2: bits added per cycle; must be ≥1, ≤width_p, and divide width_p exactly. Any violation is an elaboration-time error.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- reset_i  input  1  reset; asynchronous, active-high.
- valid_i  input  1  operands present.
- ready_o  output  1  block can accept operands.
- a_i  input  width_p  operand A (unsigned / two's complement).
- b_i  input  width_p  operand B.
- carry_i  input  1  carry-in.
- valid_o  output  1  result present.
- ready_i  input  1  consumer takes the result.
- sum_o  output  width_p  sum.
- carry_o  output  1  unsigned carry-out.
- overflow_o  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset is asynchronous and active-high.
  - Asserting reset_i forces state to IDLE immediately, without waiting for a clock edge.
  - Reset values: ready_o=1, valid_o=0, sum_o=0, carry_o=0, overflow_o=0, chunk counter=0.
  - Any in-flight operation is discarded.
- Let N = width_p/chunk_p.
- State machine has three states: IDLE, BUSY, DONE.
- IDLE:
  - ready_o=1, valid_o=0.
  - On an edge with valid_i=1, latch a_i, b_i, carry_i into internal registers, clear the counter, and go to BUSY.
  - valid_i=0 keeps the block in IDLE.
- BUSY:
  - ready_o=0, valid_o=0.
  - Each edge adds chunk k (bits [k*chunk_p +: chunk_p]) of A and B plus the carry register.
  - The chunk_p-bit result is written into the sum register at the same slice; the carry register takes the chunk carry-out.
  - The counter increments each edge.
  - On the edge processing chunk N-1:
    - record carry_o = the final carry;
    - record overflow_o = carry into bit width_p-1 XOR the final carry;
    - go to DONE.
  - valid_i is ignored while BUSY.
- DONE:
  - valid_o=1, ready_o=0.
  - sum_o, carry_o and overflow_o are stable and unchanging.
  - On an edge with ready_i=1, go to IDLE; ready_o=1 in the following cycle.
  - No same-cycle accept of new operands while in DONE.
  - ready_i=0 holds DONE indefinitely (backpressure).
  - valid_i is ignored.
- Latency: if the accept edge is edge 0, valid_o rises after edge N. There are exactly N BUSY cycles.
  - N=1 (chunk_p=width_p) gives a one-cycle BUSY.
- Throughput: one result per N+2 cycles when ready_i is held at 1.
- Arithmetic:
  - All addition is modulo 2^width_p with an explicit carry.
  - overflow_o is meaningful only for two's-complement interpretation; it is always driven.
- Output values:
  - sum_o, carry_o and overflow_o are registered.
  - Outside DONE they hold the last completed result, or 0 after reset.
  - The bench must sample them only when valid_o=1.
- Wrap-around:
  - sum 0xFF+0x01 yields 0x00 with carry_o=1; no saturation.
  - The counter resets on each accept; it never wraps mid-operation.
- Reset mid-operation (BUSY or DONE): the result is lost, the block returns to IDLE, and the next transaction is unaffected.

Test Plan:
1. Reset: width_p=8, chunk_p=2. Assert reset_i mid-cycle during BUSY -> ready_o=1, valid_o=0, sum_o=0, carry_o=0 before the next clock edge.
2. Basic add and latency: a=0x0F, b=0x01, c=0 -> sum_o=0x10, carry_o=0, overflow_o=0; valid_o high exactly 4 edges after the accept edge; ready_o low throughout.
3. Carry and overflow cases:
   - a=0xFF, b=0x01, c=0 -> sum 0x00, carry 1, ovf 0.
   - a=0x7F, b=0x00, c=1 -> sum 0x80, carry 0, ovf 1.
   - a=0x80, b=0x80, c=0 -> sum 0x00, carry 1, ovf 1.
4. Backpressure: hold ready_i=0 for 5 cycles in DONE while driving valid_i=1 with a=0x55 -> valid_o stays 1, outputs unchanged, ready_o=0. After ready_i=1, a fresh a=0x55, b=0x11 -> sum 0x66.
5. Reset mid-operation: assert reset after 2 BUSY cycles of a=0xAA, b=0x55, then run a=0x01, b=0x02, c=1 -> sum 0x04, carry 0; no residue from the aborted operation.
6. Parameter sweep:
   - width_p=4, chunk_p=1: exhaustive 512 (a,b,c) combos checked against a+b+c, with ready_i randomised.
   - width_p=8, chunk_p=8: valid_o 1 edge after accept, 0xC8+0x64 -> sum 0x2C, carry 1.
